// File: rtl/conv_tile_engine_if.sv
// =====================================================================
// Module : conv_tile_engine_if -- run request and result bundle
// Rev    : 1.0
// =====================================================================
`default_nettype none

interface conv_tile_engine_if #(
  parameter int DATA_W  = 8,
  parameter int K       = 3,
  parameter int OUT_DIM = 4,
  parameter int OUT_W   = 16
);
  localparam int c_tile_dim = OUT_DIM + K - 1;

  logic              start;
  logic              mode_signed;
  logic              relu_en;
  logic [DATA_W-1:0] input_tile [0:c_tile_dim-1][0:c_tile_dim-1];
  logic [DATA_W-1:0] kernel     [0:K-1][0:K-1];
  logic [OUT_W-1:0]  c          [0:OUT_DIM-1][0:OUT_DIM-1];
  logic              busy;
  logic              done;

  modport master (
    output start, mode_signed, relu_en, input_tile, kernel,
    input  c, busy, done
  );

  modport slave (
    input  start, mode_signed, relu_en, input_tile, kernel,
    output c, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/conv_tile_engine.sv
// =====================================================================
// Module : conv_tile_engine -- KxK correlation over an OUT_DIM^2 tile, LANES MACs
// Rev    : 1.0
// =====================================================================
`default_nettype none

module conv_tile_engine #(
  parameter int DATA_W  = 8,
  parameter int K       = 3,
  parameter int OUT_DIM = 4,
  parameter int LANES   = 5,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_tile_engine_if.slave     bus
);
  localparam int c_tile_dim = OUT_DIM + K - 1;
  localparam int c_nout     = OUT_DIM * OUT_DIM;
  localparam int c_groups   = (c_nout + LANES - 1) / LANES;
  localparam int c_kw       = (K > 1) ? $clog2(K) : 1;
  localparam int c_gw       = (c_groups > 1) ? $clog2(c_groups) : 1;
  localparam int c_tw       = $clog2(c_tile_dim);
  localparam logic [ACC_W-1:0]        c_umax = ACC_W'({OUT_W{1'b1}});
  localparam logic signed [ACC_W-1:0] c_smax = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] c_smin = ~c_smax;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_busy_nxt, w_done_nxt, w_last;
  logic   r_busy, r_done, r_signed, r_relu;

  logic [DATA_W-1:0] r_tile [0:c_tile_dim-1][0:c_tile_dim-1];
  logic [DATA_W-1:0] r_kern [0:K-1][0:K-1];
  logic [ACC_W-1:0]  r_acc  [0:c_nout-1];
  logic [OUT_W-1:0]  r_c    [0:OUT_DIM-1][0:OUT_DIM-1];
  logic [OUT_W-1:0]  w_sat  [0:c_nout-1];
  logic [c_gw-1:0]   r_g;
  logic [c_kw-1:0]   r_m, r_n;

  logic [c_tw-1:0]         w_bi    [0:LANES-1];
  logic [c_tw-1:0]         w_bj    [0:LANES-1];
  logic                    w_valid [0:LANES-1];
  logic signed [ACC_W-1:0] w_prod  [0:LANES-1];

  assign w_last = (r_g == c_gw'(c_groups - 1)) && (r_m == c_kw'(K - 1)) && (r_n == c_kw'(K - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_MAC;
        w_accept    = 1'b1;
      end
      S_MAC:   if (w_last) w_state_nxt = S_FINAL;
      S_FINAL: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_FINAL);
  end

  // Map each lane to the output pixel it serves in the current group.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_bi[l]    = '0;
      w_bj[l]    = '0;
      w_valid[l] = 1'b0;
      for (int g = 0; g < c_groups; g++) begin
        if (r_g == c_gw'(g) && (g * LANES + l) < c_nout) begin
          w_bi[l]    = c_tw'((g * LANES + l) / OUT_DIM);
          w_bj[l]    = c_tw'((g * LANES + l) % OUT_DIM);
          w_valid[l] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_W-1:0]          w_a, w_b;
      logic signed [DATA_W:0]     w_ae, w_be;
      logic signed [2*DATA_W+1:0] w_p;
      assign w_a = w_valid[l] ? r_tile[w_bi[l] + c_tw'(r_m)][w_bj[l] + c_tw'(r_n)] : '0;
      assign w_b = r_kern[r_m][r_n];
      // One extra bit lets a single signed multiplier serve both modes.
      assign w_ae = {r_signed & w_a[DATA_W-1], w_a};
      assign w_be = {r_signed & w_b[DATA_W-1], w_b};
      assign w_p  = w_ae * w_be;
      assign w_prod[l] = ACC_W'(w_p);
    end
  endgenerate

  always_comb begin
    for (int p = 0; p < c_nout; p++) begin
      w_sat[p] = r_acc[p][OUT_W-1:0];
      if (r_signed) begin
        if (r_relu && r_acc[p][ACC_W-1])      w_sat[p] = '0;
        else if ($signed(r_acc[p]) > c_smax)  w_sat[p] = OUT_W'(c_smax);
        else if ($signed(r_acc[p]) < c_smin)  w_sat[p] = OUT_W'(c_smin);
      end else if (r_acc[p] > c_umax) begin
        w_sat[p] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_signed <= 1'b0;
      r_relu   <= 1'b0;
      r_g      <= '0;
      r_m      <= '0;
      r_n      <= '0;
      for (int r = 0; r < c_tile_dim; r++)
        for (int q = 0; q < c_tile_dim; q++) r_tile[r][q] <= '0;
      for (int r = 0; r < K; r++)
        for (int q = 0; q < K; q++) r_kern[r][q] <= '0;
      for (int p = 0; p < c_nout; p++) r_acc[p] <= '0;
      for (int i = 0; i < OUT_DIM; i++)
        for (int j = 0; j < OUT_DIM; j++) r_c[i][j] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_tile   <= bus.input_tile;
        r_kern   <= bus.kernel;
        r_signed <= bus.mode_signed;
        r_relu   <= bus.relu_en;
        r_g      <= '0;
        r_m      <= '0;
        r_n      <= '0;
        for (int p = 0; p < c_nout; p++) r_acc[p] <= '0;
      end else if (r_state == S_MAC) begin
        for (int p = 0; p < c_nout; p++)
          if (r_g == c_gw'(p / LANES)) r_acc[p] <= r_acc[p] + w_prod[p % LANES];
        if (r_n == c_kw'(K - 1)) begin
          r_n <= '0;
          if (r_m == c_kw'(K - 1)) begin
            r_m <= '0;
            r_g <= r_g + 1'b1;
          end else begin
            r_m <= r_m + 1'b1;
          end
        end else begin
          r_n <= r_n + 1'b1;
        end
      end else if (r_state == S_FINAL) begin
        for (int i = 0; i < OUT_DIM; i++)
          for (int j = 0; j < OUT_DIM; j++) r_c[i][j] <= w_sat[i * OUT_DIM + j];
      end
    end
  end

  assign bus.c    = r_c;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_engine.sv
// =====================================================================
// Module : tb_conv_tile_engine -- directed checks of conv_tile_engine
// Rev    : 1.0
// =====================================================================
`default_nettype none

module tb_conv_tile_engine;
  localparam int c_n = 36;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  conv_tile_engine_if bus ();
  conv_tile_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic set_inputs(input int tv, input int kv, input bit sg, input bit rl);
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++) bus.input_tile[r][q] = 8'(tv);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) bus.kernel[r][q] = 8'(kv);
    bus.mode_signed = sg;
    bus.relu_en     = rl;
  endtask

  // Pulse start for one edge, then wait for done; lat counts edges after the start edge.
  task automatic do_run(output int lat, output int bcyc);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 0;
    bcyc = int'(bus.busy);
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_inputs(0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b done=%b exp busy=0 done=0", bus.busy, bus.done);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'd0) begin
          failures++;
          $display("FAIL reset_c[%0d][%0d] got=%0d exp=0", i, j, bus.c[i][j]);
        end
      end
    rst_n = 1'b1;
  endtask

  task automatic test_ones;
    int lat, bcyc;
    set_inputs(1, 1, 1'b0, 1'b0);
    do_run(lat, bcyc);
    checks++;
    if (lat !== c_n + 1) begin
      failures++;
      $display("FAIL ones_latency got=%0d exp=%0d", lat, c_n + 1);
    end
    checks++;
    if (bcyc !== c_n + 1) begin
      failures++;
      $display("FAIL ones_busy_cycles got=%0d exp=%0d", bcyc, c_n + 1);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'd9) begin
          failures++;
          $display("FAIL ones_c[%0d][%0d] got=%0d exp=9", i, j, bus.c[i][j]);
        end
      end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ones_done_pulse got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_sat_unsigned;
    int lat, bcyc;
    set_inputs(255, 255, 1'b0, 1'b0);
    do_run(lat, bcyc);
    checks++;
    if (lat !== c_n + 1) begin
      failures++;
      $display("FAIL usat_latency got=%0d exp=%0d", lat, c_n + 1);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'hFFFF) begin
          failures++;
          $display("FAIL usat_c[%0d][%0d] got=%h exp=ffff", i, j, bus.c[i][j]);
        end
      end
  endtask

  task automatic test_signed_relu;
    int lat, bcyc;
    set_inputs(8'hFF, 2, 1'b1, 1'b0);
    do_run(lat, bcyc);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'hFFEE) begin
          failures++;
          $display("FAIL signed_c[%0d][%0d] got=%h exp=ffee", i, j, bus.c[i][j]);
        end
      end
    set_inputs(8'hFF, 2, 1'b1, 1'b1);
    do_run(lat, bcyc);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'h0000) begin
          failures++;
          $display("FAIL relu_c[%0d][%0d] got=%h exp=0000", i, j, bus.c[i][j]);
        end
      end
  endtask

  task automatic test_ramp;
    int lat, bcyc;
    set_inputs(0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++) bus.input_tile[r][q] = 8'(6 * r + q);
    bus.kernel[1][1] = 8'd1;
    for (int rep = 0; rep < 2; rep++) begin
      do_run(lat, bcyc);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (bus.c[i][j] !== 16'(6 * (i + 1) + j + 1)) begin
            failures++;
            $display("FAIL ramp%0d_c[%0d][%0d] got=%0d exp=%0d", rep, i, j,
                     bus.c[i][j], 6 * (i + 1) + j + 1);
          end
        end
    end
  endtask

  task automatic test_mid_run_changes;
    int lat;
    set_inputs(1, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    set_inputs(3, 5, 1'b1, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 11;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== c_n + 1) begin
      failures++;
      $display("FAIL midrun_latency got=%0d exp=%0d", lat, c_n + 1);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'd9) begin
          failures++;
          $display("FAIL midrun_c[%0d][%0d] got=%0d exp=9", i, j, bus.c[i][j]);
        end
      end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_no_queue got busy=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    set_inputs(1, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b exp=0", bus.busy);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'd0) begin
          failures++;
          $display("FAIL abort_c[%0d][%0d] got=%0d exp=0", i, j, bus.c[i][j]);
        end
      end
    seen_done = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d pulses exp=0", seen_done);
    end
  endtask

  task automatic test_back_to_back;
    int t;
    set_inputs(1, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    t = 0;
    while (!bus.done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_done got=%b exp=1", bus.done);
    end
    checks++;
    if (bus.c[2][1] !== 16'd9) begin
      failures++;
      $display("FAIL b2b_first_c got=%0d exp=9", bus.c[2][1]);
    end
    set_inputs(2, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 1;
    while (!bus.done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t !== c_n + 2) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", t, c_n + 2);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (bus.c[i][j] !== 16'd18) begin
          failures++;
          $display("FAIL b2b_c[%0d][%0d] got=%0d exp=18", i, j, bus.c[i][j]);
        end
      end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_ones();
    test_sat_unsigned();
    test_signed_relu();
    test_ramp();
    test_mid_run_changes();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
